alu_issue: RTL and testbench

- Decode-side producer for the execute-stage ALU. Drives the operand pair (mux1, mux2) and the 4-bit AluSel.
- Decodes an RV32I instruction, selects register, immediate or PC operands, and maps funct3/funct7 onto the ALU op encoding.
- Results are held in a one-entry ID/EX output register with a valid/ready handshake, flush and an issued-op counter.
- Sits between the register-file read and the ALU.

---
 rtl/alu_issue_if.sv | 35 +++
 rtl/alu_issue.sv | 176 +++++++++++++++++
 tb/tb_alu_issue.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Decode-to-ALU issue bundle: instruction/operand side in, registered ALU operands out.
// master = the issuing block, slave = the decode/execute environment around it.
interface alu_issue_if #(
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;
    logic             flush;
    logic             ex_ready;
    logic             out_valid;
    logic [31:0]      mux1;
    logic [31:0]      mux2;
    logic [3:0]       AluSel;
    logic [4:0]       out_rd;
    logic             out_wb_en;
    logic [31:0]      out_pc;
    logic             out_illegal;
    logic [CNT_W-1:0] issue_count;

    modport master (
        input  in_valid, instr, pc, rs1_data, rs2_data, flush, ex_ready,
        output in_ready, out_valid, mux1, mux2, AluSel, out_rd, out_wb_en,
               out_pc, out_illegal, issue_count
    );

    modport slave (
        output in_valid, instr, pc, rs1_data, rs2_data, flush, ex_ready,
        input  in_ready, out_valid, mux1, mux2, AluSel, out_rd, out_wb_en,
               out_pc, out_illegal, issue_count
    );
endinterface

// File: rtl/alu_issue.sv
// Purpose: decode RV32I, select ALU operands/op and hold them in a one-entry ID/EX register.
// Latency: one cycle from capture edge to out_*.
// Backpressure: in_ready = !out_valid || ex_ready; a stalled entry holds bit-stable.
module alu_issue #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter int          CNT_W    = 32
) (
    input  logic        clock,
    input  logic        reset,
    alu_issue_if.master bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] SEL_ADD  = 4'b0000;
    localparam logic [3:0] SEL_SUB  = 4'b0001;
    localparam logic [3:0] SEL_SRL  = 4'b0010;
    localparam logic [3:0] SEL_SLL  = 4'b0011;
    localparam logic [3:0] SEL_XOR  = 4'b0100;
    localparam logic [3:0] SEL_OR   = 4'b0101;
    localparam logic [3:0] SEL_AND  = 4'b0110;
    localparam logic [3:0] SEL_SLT  = 4'b0111;
    localparam logic [3:0] SEL_SLTU = 4'b1000;
    localparam logic [3:0] SEL_SRA  = 4'b1001;
    localparam logic [3:0] SEL_ILL  = 4'b1111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] mux1;
        logic [31:0] mux2;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        wb_en;
        logic        illegal;
        logic [31:0] pc;
    } entry_t;

    entry_t           dec;
    entry_t           entry_q;
    logic             valid_q;
    logic [CNT_W-1:0] count_q;
    logic             in_ready;
    logic             capture;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];
    assign imm_i  = {{20{bus.instr[31]}}, bus.instr[31:20]};
    assign imm_s  = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
    assign imm_u  = {bus.instr[31:12], 12'b0};

    // Shared funct3 -> op mapping for register and immediate arithmetic.
    function automatic logic [3:0] arith_sel(input logic [2:0] f3);
        case (f3)
            3'b000:  return SEL_ADD;
            3'b001:  return SEL_SLL;
            3'b010:  return SEL_SLT;
            3'b011:  return SEL_SLTU;
            3'b100:  return SEL_XOR;
            3'b101:  return SEL_SRL;
            3'b110:  return SEL_OR;
            default: return SEL_AND;
        endcase
    endfunction

    always_comb begin
        dec         = '0;
        dec.mux1    = bus.rs1_data;
        dec.mux2    = bus.rs2_data;
        dec.sel     = SEL_ADD;
        dec.rd      = bus.instr[11:7];
        dec.wb_en   = 1'b1;
        dec.illegal = 1'b0;
        dec.pc      = bus.pc;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE)                          dec.sel = arith_sel(funct3);
                else if (funct7 == F7_ALT && funct3 == 3'b000)  dec.sel = SEL_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101)  dec.sel = SEL_SRA;
                else                                            dec.illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.mux2 = imm_i;
                if (funct3 == 3'b001) begin
                    if (funct7 == F7_BASE) dec.sel = SEL_SLL;
                    else                   dec.illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_BASE)     dec.sel = SEL_SRL;
                    else if (funct7 == F7_ALT) dec.sel = SEL_SRA;
                    else                       dec.illegal = 1'b1;
                end else begin
                    dec.sel = arith_sel(funct3);
                end
            end
            OPC_LUI: begin
                dec.mux1 = 32'd0;
                dec.mux2 = imm_u;
            end
            OPC_AUIPC: begin
                dec.mux1 = bus.pc;
                dec.mux2 = imm_u;
            end
            OPC_LOAD: dec.mux2 = imm_i;
            OPC_STORE: begin
                dec.mux2  = imm_s;
                dec.wb_en = 1'b0;
            end
            OPC_JAL, OPC_JALR: begin
                dec.mux1 = bus.pc;
                dec.mux2 = 32'd4;
            end
            OPC_BRANCH: begin
                dec.wb_en = 1'b0;
                case (funct3)
                    3'b000, 3'b001: dec.sel = SEL_SUB;
                    3'b100, 3'b101: dec.sel = SEL_SLT;
                    3'b110, 3'b111: dec.sel = SEL_SLTU;
                    default:        dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
        // Illegal entries still issue, but carry neutral operands.
        if (dec.illegal) begin
            dec.sel   = SEL_ILL;
            dec.mux1  = 32'd0;
            dec.mux2  = 32'd0;
            dec.wb_en = 1'b0;
        end
        if (dec.rd == 5'd0) dec.wb_en = 1'b0;
    end

    assign in_ready = !valid_q || bus.ex_ready;
    assign capture  = bus.in_valid && in_ready && !bus.flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            entry_q    <= '0;
            entry_q.pc <= RESET_PC;
            count_q    <= '0;
        end else begin
            if (bus.flush)    valid_q <= 1'b0;
            else if (in_ready) valid_q <= bus.in_valid;
            if (capture) entry_q <= dec;
            if (valid_q && bus.ex_ready && !bus.flush) count_q <= count_q + 1'b1;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = valid_q;
    assign bus.mux1        = entry_q.mux1;
    assign bus.mux2        = entry_q.mux2;
    assign bus.AluSel      = entry_q.sel;
    assign bus.out_rd      = entry_q.rd;
    assign bus.out_wb_en   = entry_q.wb_en;
    assign bus.out_pc      = entry_q.pc;
    assign bus.out_illegal = entry_q.illegal;
    assign bus.issue_count = count_q;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed steps plus random traffic, checked against a mnemonic-level
// reference model of the issue slot.
module tb_alu_issue;
    localparam logic [31:0] RPC = 32'h0100_0000;
    localparam int          CW  = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    alu_issue_if #(.CNT_W(CW)) bus ();
    alu_issue #(.RESET_PC(RPC), .CNT_W(CW)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [31:0] m1;
        logic [31:0] m2;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        wb;
        logic        ill;
    } exp_t;

    logic        m_valid;
    exp_t        m_dec;
    logic [31:0] m_pc;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic string arith_name(input logic [2:0] f3);
        case (f3)
            3'd0: return "add";  3'd1: return "sll";  3'd2: return "slt";  3'd3: return "sltu";
            3'd4: return "xor";  3'd5: return "srl";  3'd6: return "or";   default: return "and";
        endcase
    endfunction

    function automatic string mnem(input logic [31:0] i);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = i[14:12];
        f7 = i[31:25];
        case (i[6:0])
            7'h33: begin
                if (f7 == 7'h00) return arith_name(f3);
                if (f7 == 7'h20 && f3 == 3'd0) return "sub";
                if (f7 == 7'h20 && f3 == 3'd5) return "sra";
                return "ill";
            end
            7'h13: begin
                if (f3 == 3'd1) return (f7 == 7'h00) ? "sll" : "ill";
                if (f3 == 3'd5) return (f7 == 7'h00) ? "srl" : (f7 == 7'h20) ? "sra" : "ill";
                return arith_name(f3);
            end
            7'h37: return "lui";
            7'h17: return "auipc";
            7'h03: return "load";
            7'h23: return "store";
            7'h6f: return "jal";
            7'h67: return "jalr";
            7'h63: begin
                if (f3 == 3'd0 || f3 == 3'd1) return "sub";
                if (f3 == 3'd4 || f3 == 3'd5) return "slt";
                if (f3 == 3'd6 || f3 == 3'd7) return "sltu";
                return "ill";
            end
            default: return "ill";
        endcase
    endfunction

    function automatic logic [3:0] sel_of(input string m);
        if (m == "sub")  return 4'd1;
        if (m == "srl")  return 4'd2;
        if (m == "sll")  return 4'd3;
        if (m == "xor")  return 4'd4;
        if (m == "or")   return 4'd5;
        if (m == "and")  return 4'd6;
        if (m == "slt")  return 4'd7;
        if (m == "sltu") return 4'd8;
        if (m == "sra")  return 4'd9;
        if (m == "ill")  return 4'd15;
        return 4'd0;
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] p,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t  d;
        string m;
        logic [31:0] imm_i, imm_s, imm_u;
        imm_i = 32'($signed(i[31:20]));
        imm_s = 32'($signed({i[31:25], i[11:7]}));
        imm_u = i & 32'hFFFF_F000;
        m     = mnem(i);
        d.sel = sel_of(m);
        d.rd  = i[11:7];
        d.ill = (m == "ill");
        d.m1  = r1;
        d.m2  = r2;
        d.wb  = 1'b1;
        case (i[6:0])
            7'h13, 7'h03: d.m2 = imm_i;
            7'h37:        begin d.m1 = 0;  d.m2 = imm_u; end
            7'h17:        begin d.m1 = p;  d.m2 = imm_u; end
            7'h23:        begin d.m2 = imm_s; d.wb = 1'b0; end
            7'h6f, 7'h67: begin d.m1 = p;  d.m2 = 32'd4; end
            7'h63:        d.wb = 1'b0;
            default: ;
        endcase
        if (d.ill) begin d.m1 = 0; d.m2 = 0; d.wb = 1'b0; end
        if (d.rd == 5'd0) d.wb = 1'b0;
        return d;
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9];
        logic [31:0] w;
        int          k;
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h6f, 7'h67, 7'h63};
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 9) w[6:0] = ops[k];
        k = $urandom_range(0, 3);
        if (k == 0) w[31:25] = 7'h00;
        else if (k == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_dec   = '0;
        m_pc    = RPC;
        m_cnt   = 0;
    endtask

    task automatic check_all();
        chk("out_valid",   32'(bus.out_valid),   32'(m_valid));
        chk("mux1",        bus.mux1,             m_dec.m1);
        chk("mux2",        bus.mux2,             m_dec.m2);
        chk("AluSel",      32'(bus.AluSel),      32'(m_dec.sel));
        chk("out_rd",      32'(bus.out_rd),      32'(m_dec.rd));
        chk("out_wb_en",   32'(bus.out_wb_en),   32'(m_dec.wb));
        chk("out_illegal", 32'(bus.out_illegal), 32'(m_dec.ill));
        chk("out_pc",      bus.out_pc,           m_pc);
        chk("issue_count", 32'(bus.issue_count), 32'(m_cnt));
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2, input logic er, input logic fl);
        bus.in_valid = iv;
        bus.instr    = ins;
        bus.pc       = p;
        bus.rs1_data = r1;
        bus.rs2_data = r2;
        bus.ex_ready = er;
        bus.flush    = fl;
    endtask

    // One clock: check in_ready before the edge, advance the model, check all outputs after it.
    task automatic cycle();
        exp_t d;
        logic rdy;
        #1;
        rdy = !m_valid || bus.ex_ready;
        chk("in_ready", 32'(bus.in_ready), 32'(rdy));
        d = ref_decode(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data);
        @(posedge clock);
        if (m_valid && bus.ex_ready && !bus.flush) m_cnt = (m_cnt + 1) % (1 << CW);
        if (bus.flush) m_valid = 1'b0;
        else if (rdy) begin
            m_valid = bus.in_valid;
            if (bus.in_valid) begin
                m_dec = d;
                m_pc  = bus.pc;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        int c0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        #12;
        check_all();
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // add x3,x1,x2
        drive(1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h100, 32'd5, 32'd7, 1, 0);
        cycle();
        chk("add_mux1", bus.mux1, 32'd5);
        chk("add_sel",  32'(bus.AluSel), 32'd0);
        chk("add_wb",   32'(bus.out_wb_en), 32'd1);
        bus.in_valid = 1'b0;
        cycle();
        chk("add_count", 32'(bus.issue_count), 32'd1);

        // srai x4,x5,3 and the same with a bad funct7
        drive(1, enc_i(12'h403, 5'd5, 3'd5, 5'd4, 7'h13), 32'h104, 32'h8000_0000, 0, 1, 0);
        cycle();
        chk("srai_sel",   32'(bus.AluSel), 32'd9);
        chk("srai_shamt", 32'(bus.mux2[4:0]), 32'd3);
        bus.instr = enc_i(12'h023, 5'd5, 3'd5, 5'd4, 7'h13);
        cycle();
        chk("srai_bad_sel", 32'(bus.AluSel), 32'd15);
        chk("srai_bad_ill", 32'(bus.out_illegal), 32'd1);
        chk("srai_bad_wb",  32'(bus.out_wb_en), 32'd0);

        // auipc x1,0x12345 at pc 0x1000, then bltu
        drive(1, {20'h12345, 5'd1, 7'h17}, 32'h1000, 0, 0, 1, 0);
        cycle();
        chk("auipc_mux1", bus.mux1, 32'h1000);
        chk("auipc_mux2", bus.mux2, 32'h1234_5000);
        drive(1, enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd0, 7'h63), 32'h1004, 32'd1, 32'd2, 1, 0);
        cycle();
        chk("bltu_sel", 32'(bus.AluSel), 32'd8);
        chk("bltu_wb",  32'(bus.out_wb_en), 32'd0);

        // Stall three cycles with a new instruction waiting, then release
        drive(1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd7, 7'h33), 32'h200, 32'd11, 32'd22, 1, 0);
        cycle();
        drive(1, enc_r(7'h00, 5'd4, 5'd3, 3'd4, 5'd8, 7'h33), 32'h204, 32'hF0F0, 32'h0FF0, 0, 0);
        c0 = m_cnt;
        for (int s = 0; s < 3; s++) begin
            cycle();
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_mux1", bus.mux1, 32'd11);
            chk("stall_count", 32'(bus.issue_count), 32'(c0));
        end
        bus.ex_ready = 1'b1;
        cycle();
        chk("release_sel",   32'(bus.AluSel), 32'd4);
        chk("release_count", 32'(bus.issue_count), 32'((c0 + 1) % 16));

        // Flush a stalled entry, then flush together with a capture
        bus.in_valid = 1'b0;
        bus.ex_ready = 1'b0;
        cycle();
        c0 = m_cnt;
        bus.flush    = 1'b1;
        bus.ex_ready = 1'b1;
        cycle();
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_count", 32'(bus.issue_count), 32'(c0));
        bus.in_valid = 1'b1;
        cycle();
        chk("flush_cap_valid", 32'(bus.out_valid), 32'd0);
        bus.flush = 1'b0;

        // 16 back-to-back issues wrap the 4-bit counter
        bus.in_valid = 1'b0;
        cycle();
        c0 = m_cnt;
        for (int n = 0; n < 16; n++) begin
            drive(1, enc_i(12'(n), 5'd1, 3'd0, 5'(n + 1), 7'h13), 32'h300 + 32'(4 * n), 32'(n), 0, 1, 0);
            cycle();
        end
        bus.in_valid = 1'b0;
        cycle();
        chk("wrap_count", 32'(bus.issue_count), 32'(c0));

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            cycle();
        end

        // Reset asserted in the middle of a stall
        drive(1, {20'hABCDE, 5'd9, 7'h37}, 32'h400, 0, 0, 1, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_pc", bus.out_pc, RPC);
        for (int n = 0; n < 2; n++) begin
            @(posedge clock);
            #1;
            check_all();
        end
        reset = 1'b1;
        drive(1, enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd5, 7'h33), 32'h500, 32'd9, 32'd4, 1, 0);
        cycle();
        bus.in_valid = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
